twpm_wb_decoder: RTL and testbench
==================================

TWPM_WB_DECODER -- requirements
Module: twpm_wb_decoder

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- RAM_BASE, 32'h80000000, DDR3 data window base.
- RAM_AW, 27, DDR3 window address width.
- CTRL_BASE, 32'hF8000000, LiteDRAM controller window base.
- CTRL_AW, 14, controller window address width.
- TPM_BASE, 32'hF0000000, TPM registers and buffer window base.
- TPM_AW, 12, TPM window address width.
- TIMEOUT_CYCLES, 255, watchdog limit in clocks (1..255).
REQ-002 clk_i  in  1  CPU/Wishbone clock (50 MHz); the block has one clock; reset is asynchronous and active-low.
REQ-003 rstn_i  in  1  asynchronous active-low reset.
REQ-004 m_adr_i, m_dat_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i  in  32/32/4/1/1/1  CPU master request.
REQ-005 m_dat_o, m_ack_o, m_err_o  out  32/1/1  CPU master response.
REQ-006 s_adr_o, s_dat_o, s_sel_o, s_we_o  out  32/32/4/1  shared request bus to all slaves.
REQ-007 s_cyc_o, s_stb_o  out  3/3  per-slave strobes; index 0 is RAM, 1 is CTRL, 2 is TPM.
REQ-008 s_ack_i, s_err_i  in  3/3  per-slave responses.
REQ-009 s_dat_i  in  96  per-slave read data; slave n uses bits [32n+31:32n].
REQ-010 busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-011 Decode SHALL be: slave n hit when m_adr_i[31:AW_n] equals BASE_n[31:AW_n]; priority is RAM, then CTRL, then TPM; no hit means unmapped.
REQ-012 The FSM SHALL have states IDLE, ACTIVE, RESP.
REQ-013 IDLE: on m_cyc_i and m_stb_i, the block SHALL register the address, write data, sel, we and the decoded index; mapped goes to ACTIVE, unmapped goes to RESP with the error flag set.
REQ-014 ACTIVE: s_cyc_o[idx] and s_stb_o[idx] SHALL be 1; all other strobe bits SHALL be 0; s_adr_o, s_dat_o, s_sel_o and s_we_o SHALL be the registered copies, stable for the whole access.
REQ-015 ACTIVE: the first s_ack_i[idx] or s_err_i[idx] SHALL capture s_dat_i slice idx and the error flag, then go to RESP; strobes SHALL drop in the same cycle as the transition.
REQ-016 RESP: the block SHALL pulse exactly one of m_ack_o or m_err_o for exactly one cycle, with m_dat_o valid, then return to IDLE.
REQ-017 Responses on non-selected slave ack/err inputs SHALL be ignored.
REQ-018 If s_ack_i[idx] and s_err_i[idx] are asserted together, the response SHALL be treated as an error.
REQ-019 Latency for a mapped access SHALL be 2 clocks plus the slave latency, measured from request accept to m_ack_o.
REQ-020 Latency for an unmapped access SHALL be m_err_o exactly 2 cycles after the stb cycle.
REQ-021 If m_cyc_i drops in ACTIVE, the block SHALL return to IDLE the next cycle with slave strobes low and no master response.
REQ-022 m_dat_o SHALL be 32'hBADFABAC on any error response.
REQ-023 A new request SHALL be accepted no earlier than the cycle after RESP (back-to-back throughput: 1 access per latency+1 clocks).

Reset
REQ-024 While rstn_i is low: FSM=IDLE, s_cyc_o=0, s_stb_o=0, m_ack_o=0, m_err_o=0, busy_o=0, m_dat_o=0, watchdog=0.
REQ-025 Reset asserted mid-access SHALL abandon the access immediately with no response pulse.

Configuration
REQ-026 Macro TWPM_WB_TIMEOUT_EN: when defined, an 8-bit watchdog SHALL clear on entry to ACTIVE and increment each ACTIVE cycle.
REQ-027 With TWPM_WB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL drop the slave strobes and go to RESP with an error.
REQ-028 With TWPM_WB_TIMEOUT_EN undefined, no counter SHALL exist and ACTIVE SHALL wait indefinitely.

Structure
REQ-029 A shared package twpm_pkg SHALL hold: slave index constants (SLV_RAM=0, SLV_CTRL=1, SLV_TPM=2, NUM_SLV=3), the base/width defaults, the BAD_ACCESS constant 32'hBADFABAC, and the FSM state encoding.
REQ-030 The address decode SHALL be one sub-module, twpm_wb_addr_match (combinational compare of address against base/width), instantiated once per slave.

Verification
REQ-031 Read 0x80000010, RAM acks 3 cycles after stb with 0x12345678 -> m_ack_o one cycle, m_dat_o=0x12345678, s_stb_o=3'b001 only during ACTIVE.
REQ-032 Write 0xF8000004 data 0x1 sel 4'hF, CTRL acks immediately -> s_stb_o=3'b010, s_dat_o=0x1, m_ack_o 2 cycles after accept.
REQ-033 Read 0x00001000 -> no slave strobe, m_err_o exactly 2 cycles after the stb cycle, m_dat_o=0xBADFABAC.
REQ-034 TPM access to 0xF0000040 with slave silent, TWPM_WB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16 -> m_err_o after 16 ACTIVE cycles, then IDLE.
REQ-035 Assert rstn_i low during ACTIVE; separately drop m_cyc_i during ACTIVE -> strobes low next cycle, no ack/err, next request served normally.
REQ-036 CTRL asserts s_ack_i[1] during a RAM access -> ignored; completion only on s_ack_i[0].

Source files
------------

// File: rtl/twpm_pkg.sv
// Shared constants for the TWPM Wishbone decoder: slave indices, window
// defaults, the bad-access read value and the decoder FSM state encoding.
package twpm_pkg;

    localparam int SLV_RAM  = 0;
    localparam int SLV_CTRL = 1;
    localparam int SLV_TPM  = 2;
    localparam int NUM_SLV  = 3;

    localparam logic [31:0] RAM_BASE_DEF  = 32'h8000_0000;
    localparam int          RAM_AW_DEF    = 27;
    localparam logic [31:0] CTRL_BASE_DEF = 32'hF800_0000;
    localparam int          CTRL_AW_DEF   = 14;
    localparam logic [31:0] TPM_BASE_DEF  = 32'hF000_0000;
    localparam int          TPM_AW_DEF    = 12;

    localparam logic [31:0] BAD_ACCESS = 32'hBADF_ABAC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/twpm_wb_addr_match.sv
// Combinational window compare: hit when the address bits above AW equal
// the corresponding bits of BASE.
module twpm_wb_addr_match #(
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter int          AW   = 12
) (
    input  logic [31:0] adr,
    output logic        hit
);

    assign hit = ((adr >> AW) == (BASE >> AW));

endmodule

// File: rtl/twpm_wb_decoder.sv
// Wishbone 1-to-3 decoder (RAM, LiteDRAM control, TPM) with registered
// request and response. Optional watchdog enabled by TWPM_WB_TIMEOUT_EN.
module twpm_wb_decoder
    import twpm_pkg::*;
#(
    parameter logic [31:0] RAM_BASE       = RAM_BASE_DEF,
    parameter int          RAM_AW         = RAM_AW_DEF,
    parameter logic [31:0] CTRL_BASE      = CTRL_BASE_DEF,
    parameter int          CTRL_AW        = CTRL_AW_DEF,
    parameter logic [31:0] TPM_BASE       = TPM_BASE_DEF,
    parameter int          TPM_AW         = TPM_AW_DEF,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [31:0]            m_adr_i,
    input  logic [31:0]            m_dat_i,
    input  logic [3:0]             m_sel_i,
    input  logic                   m_we_i,
    input  logic                   m_stb_i,
    input  logic                   m_cyc_i,
    output logic [31:0]            m_dat_o,
    output logic                   m_ack_o,
    output logic                   m_err_o,
    output logic [31:0]            s_adr_o,
    output logic [31:0]            s_dat_o,
    output logic [3:0]             s_sel_o,
    output logic                   s_we_o,
    output logic [NUM_SLV-1:0]     s_cyc_o,
    output logic [NUM_SLV-1:0]     s_stb_o,
    input  logic [NUM_SLV-1:0]     s_ack_i,
    input  logic [NUM_SLV-1:0]     s_err_i,
    input  logic [32*NUM_SLV-1:0]  s_dat_i,
    output logic                   busy_o
);

    state_t              state, state_nxt;
    logic [NUM_SLV-1:0]  hit;
    logic                dec_hit;
    logic [1:0]          dec_idx;
    logic [1:0]          idx_q;
    logic                err_q;
    logic [31:0]         rdata_q;
    logic [31:0]         slv_rdata;
    logic [NUM_SLV-1:0]  idx_oh;
    logic                slv_ack, slv_err;
    logic                accept;
    logic                timeout;

    twpm_wb_addr_match #(.BASE(RAM_BASE),  .AW(RAM_AW))  u_match_ram  (.adr(m_adr_i), .hit(hit[SLV_RAM]));
    twpm_wb_addr_match #(.BASE(CTRL_BASE), .AW(CTRL_AW)) u_match_ctrl (.adr(m_adr_i), .hit(hit[SLV_CTRL]));
    twpm_wb_addr_match #(.BASE(TPM_BASE),  .AW(TPM_AW))  u_match_tpm  (.adr(m_adr_i), .hit(hit[SLV_TPM]));

    always_comb begin
        dec_hit = 1'b1;
        dec_idx = 2'd0;
        if (hit[SLV_RAM])       dec_idx = 2'(SLV_RAM);
        else if (hit[SLV_CTRL]) dec_idx = 2'(SLV_CTRL);
        else if (hit[SLV_TPM])  dec_idx = 2'(SLV_TPM);
        else                    dec_hit = 1'b0;
    end

    // Only the selected slave's response lines are looked at.
    assign idx_oh  = NUM_SLV'(3'b001 << idx_q);
    assign slv_ack = |(s_ack_i & idx_oh);
    assign slv_err = |(s_err_i & idx_oh);

    always_comb begin
        slv_rdata = s_dat_i[31:0];
        case (idx_q)
            2'd1:    slv_rdata = s_dat_i[63:32];
            2'd2:    slv_rdata = s_dat_i[95:64];
            default: slv_rdata = s_dat_i[31:0];
        endcase
    end

    // The response pulse is registered one cycle behind RESP, so a master still
    // holding stb during its ack cycle must not be taken as a fresh request.
    assign accept = m_cyc_i && m_stb_i && !m_ack_o && !m_err_o;

`ifdef TWPM_WB_TIMEOUT_EN
    logic [7:0] wdog;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                wdog <= '0;
        else if (state == ST_IDLE)  wdog <= '0;
        else if (state == ST_ACTIVE) wdog <= wdog + 8'd1;
    end

    assign timeout = (wdog == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = dec_hit ? ST_ACTIVE : ST_RESP;
            end
            ST_ACTIVE: begin
                if (!m_cyc_i)                            state_nxt = ST_IDLE;
                else if (slv_ack || slv_err || timeout)  state_nxt = ST_RESP;
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= ST_IDLE;
            s_adr_o <= '0;
            s_dat_o <= '0;
            s_sel_o <= '0;
            s_we_o  <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_dat_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && accept) begin
                s_adr_o <= m_adr_i;
                s_dat_o <= m_dat_i;
                s_sel_o <= m_sel_i;
                s_we_o  <= m_we_i;
                idx_q   <= dec_idx;
                err_q   <= !dec_hit;
            end else if (state == ST_ACTIVE && m_cyc_i) begin
                if (slv_ack || slv_err) begin
                    rdata_q <= slv_rdata;
                    err_q   <= slv_err;
                end else if (timeout) begin
                    err_q   <= 1'b1;
                end
            end
            m_ack_o <= (state == ST_RESP) && !err_q;
            m_err_o <= (state == ST_RESP) && err_q;
            if (state == ST_RESP) m_dat_o <= err_q ? BAD_ACCESS : rdata_q;
        end
    end

    assign s_cyc_o = (state == ST_ACTIVE) ? idx_oh : '0;
    assign s_stb_o = (state == ST_ACTIVE) ? idx_oh : '0;
    assign busy_o  = (state != ST_IDLE);

endmodule

// File: tb/tb_twpm_wb_decoder.sv
// Self-checking bench for twpm_wb_decoder: randomised accesses against a
// window/latency model, plus cyc-drop, reset, silent-slave and throughput cases.
module tb_twpm_wb_decoder;

    localparam int          TMO = 16;
    localparam logic [31:0] BAD = 32'hBADF_ABAC;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] m_adr = '0, m_wdat = '0;
    logic [3:0]  m_sel = '0;
    logic        m_we = 1'b0, m_stb = 1'b0, m_cyc = 1'b0;
    logic [31:0] m_dat_o;
    logic        m_ack_o, m_err_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o;
    logic [2:0]  s_cyc_o, s_stb_o;
    logic [2:0]  s_ack = '0, s_err = '0;
    logic [95:0] s_dat = '0;
    logic        busy_o;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int          n;
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic        bus_ok;
        int          stb_cycles;
        logic        busy_end;
    } obs_t;

    always #5 clk = ~clk;

    twpm_wb_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .m_adr_i(m_adr), .m_dat_i(m_wdat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_stb_i(m_stb), .m_cyc_i(m_cyc),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_dat),
        .busy_o(busy_o)
    );

    // Address windows as plain ranges: RAM 128 MiB, CTRL 16 KiB, TPM 4 KiB.
    function automatic int ref_slave(input logic [31:0] a);
        longint ua = longint'({32'b0, a});
        if (ua >= 64'h8000_0000 && ua < 64'h8000_0000 + (64'd1 << 27)) return 0;
        if (ua >= 64'hF800_0000 && ua < 64'hF800_0000 + (64'd1 << 14)) return 1;
        if (ua >= 64'hF000_0000 && ua < 64'hF000_0000 + (64'd1 << 12)) return 2;
        return -1;
    endfunction

    // Drives one master request (caller sits at a negedge) and plays the slaves.
    // lat < 0 means the addressed slave never answers; mode 0..3 ack, 4 err, 5 both.
    task automatic run_access(input logic [31:0] adr, input logic [31:0] wdat,
                              input logic [3:0] sel, input logic we, input int lat,
                              input int mode, input logic [31:0] rdata,
                              input int budget, output obs_t o);
        int         exp = ref_slave(adr);
        int         active = 0;
        logic [2:0] own = (exp >= 0) ? 3'(1 << exp) : 3'b000;
        o.n = -1; o.ack = 1'b0; o.err = 1'b0; o.dat = '0;
        o.bus_ok = 1'b1; o.stb_cycles = 0; o.busy_end = 1'b0;
        m_adr = adr; m_wdat = wdat; m_sel = sel; m_we = we;
        m_cyc = 1'b1; m_stb = 1'b1;
        s_ack = '0; s_err = '0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            s_ack = 3'($urandom) & ~own;
            s_err = 3'($urandom) & ~own;
            s_dat = {$urandom, $urandom, $urandom};
            if (m_ack_o || m_err_o) begin
                o.n = n; o.ack = m_ack_o; o.err = m_err_o; o.dat = m_dat_o;
                break;
            end
            if (s_stb_o != 3'b000) begin
                o.stb_cycles++;
                active++;
                if (s_stb_o != own || s_cyc_o != own || s_adr_o != adr ||
                    s_dat_o != wdat || s_sel_o != sel || s_we_o != we)
                    o.bus_ok = 1'b0;
                if (lat >= 0 && active == lat + 1) begin
                    s_ack[exp] = (mode != 4);
                    s_err[exp] = (mode >= 4);
                    s_dat[32*exp +: 32] = rdata;
                end
            end else if (s_cyc_o != 3'b000) begin
                o.bus_ok = 1'b0;
            end
        end
        o.busy_end = busy_o;
        m_cyc = 1'b0; m_stb = 1'b0;
        s_ack = '0; s_err = '0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_cyc_o, s_stb_o, m_ack_o, m_err_o, busy_o} !== 9'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got %b required 0", {s_cyc_o, s_stb_o, m_ack_o, m_err_o, busy_o});
        end
        checks++;
        if (m_dat_o !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_dat: got %h required 0", m_dat_o);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [31:0] adr_t [5] = '{32'h8000_0010, 32'hF800_0004, 32'h0000_1000, 32'h8123_4560, 32'hF000_0040};
        logic [31:0] wd_t  [5] = '{32'h0, 32'h1, 32'h0, 32'h0, 32'hCAFE_0001};
        logic        we_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int          lat_t [5] = '{2, 0, 0, 3, 1};
        int          mode_t[5] = '{0, 0, 0, 0, 5};
        logic [31:0] rd_t  [5] = '{32'h1234_5678, 32'h0, 32'h0, 32'hA5A5_5A5A, 32'h7777_0000};
        obs_t o;
        for (int i = 0; i < 5; i++) begin
            int   exp = ref_slave(adr_t[i]);
            logic exp_err = (exp < 0) || (mode_t[i] >= 4);
            int   exp_n = (exp < 0) ? 2 : lat_t[i] + 3;
            run_access(adr_t[i], wd_t[i], 4'hF, we_t[i], lat_t[i], mode_t[i], rd_t[i], 40, o);
            checks++;
            if (o.n !== exp_n) begin
                fails++; $display("[TB] FAIL dir_latency[%0d]: got %0d required %0d", i, o.n, exp_n);
            end
            checks++;
            if (o.ack !== !exp_err || o.err !== exp_err) begin
                fails++; $display("[TB] FAIL dir_kind[%0d]: got ack=%b err=%b required err=%b", i, o.ack, o.err, exp_err);
            end
            checks++;
            if (o.dat !== (exp_err ? BAD : rd_t[i])) begin
                fails++; $display("[TB] FAIL dir_data[%0d]: got %h required %h", i, o.dat, exp_err ? BAD : rd_t[i]);
            end
            checks++;
            if (!o.bus_ok || o.stb_cycles != ((exp < 0) ? 0 : lat_t[i] + 1)) begin
                fails++; $display("[TB] FAIL dir_bus[%0d]: got ok=%b stb_cycles=%0d", i, o.bus_ok, o.stb_cycles);
            end
            @(negedge clk);
            checks++;
            if (m_ack_o || m_err_o || busy_o) begin
                fails++; $display("[TB] FAIL dir_pulse[%0d]: got ack=%b err=%b busy=%b required 0", i, m_ack_o, m_err_o, busy_o);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] bases [3] = '{32'h8000_0000, 32'hF800_0000, 32'hF000_0000};
        logic [31:0] sizes [3] = '{32'h0800_0000, 32'h0000_4000, 32'h0000_1000};
        obs_t o;
        for (int i = 0; i < 40; i++) begin
            int          r = $urandom_range(0, 2);
            int          lat = $urandom_range(0, 4);
            int          mode = $urandom_range(0, 5);
            logic [31:0] rd = $urandom;
            logic [31:0] adr;
            int          exp;
            logic        exp_err;
            int          exp_n;
            case ($urandom_range(0, 4))
                0, 1, 2: adr = bases[r] + ($urandom & (sizes[r] - 1));
                3: case ($urandom_range(0, 2))
                       0:       adr = bases[r] - 1;
                       1:       adr = bases[r] + sizes[r] - 1;
                       default: adr = bases[r] + sizes[r];
                   endcase
                default: adr = $urandom;
            endcase
            exp = ref_slave(adr);
            exp_err = (exp < 0) || (mode >= 4);
            exp_n = (exp < 0) ? 2 : lat + 3;
            run_access(adr, $urandom, 4'($urandom), 1'($urandom), lat, mode, rd, 40, o);
            checks++;
            if (o.n !== exp_n) begin
                fails++; $display("[TB] FAIL rand_latency[%0d] adr=%h: got %0d required %0d", i, adr, o.n, exp_n);
            end
            checks++;
            if (o.ack !== !exp_err || o.err !== exp_err) begin
                fails++; $display("[TB] FAIL rand_kind[%0d] adr=%h: got ack=%b err=%b required err=%b", i, adr, o.ack, o.err, exp_err);
            end
            checks++;
            if (o.dat !== (exp_err ? BAD : rd)) begin
                fails++; $display("[TB] FAIL rand_data[%0d] adr=%h: got %h required %h", i, adr, o.dat, exp_err ? BAD : rd);
            end
            checks++;
            if (!o.bus_ok || o.stb_cycles != ((exp < 0) ? 0 : lat + 1)) begin
                fails++; $display("[TB] FAIL rand_bus[%0d] adr=%h: got ok=%b stb_cycles=%0d", i, adr, o.bus_ok, o.stb_cycles);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int    lats [6] = '{0, 1, 3, 0, 2, 0};
        longint t0, expected = 0;
        obs_t  o;
        t0 = longint'($time);
        for (int i = 0; i < 6; i++) begin
            run_access(32'hF000_0100 + 32'(i * 4), 32'h0, 4'hF, 1'b0, lats[i], 0, 32'h100 + 32'(i), 40, o);
            expected += longint'((lats[i] + 4) * 10);
            checks++;
            if (o.n !== lats[i] + 3 || o.dat !== 32'h100 + 32'(i)) begin
                fails++; $display("[TB] FAIL b2b_access[%0d]: got n=%0d dat=%h required n=%0d", i, o.n, o.dat, lats[i] + 3);
            end
            @(negedge clk);
        end
        checks++;
        if (longint'($time) - t0 != expected) begin
            fails++; $display("[TB] FAIL b2b_throughput: got %0d required %0d", longint'($time) - t0, expected);
        end
    endtask

    task automatic test_cyc_drop;
        obs_t o;
        run_access(32'h8000_0200, 32'h0, 4'hF, 1'b0, -1, 0, 32'h0, 3, o);
        checks++;
        if (o.stb_cycles != 3 || !o.busy_end) begin
            fails++; $display("[TB] FAIL cyc_drop_active: got stb_cycles=%0d busy=%b required 3 and 1", o.stb_cycles, o.busy_end);
        end
        @(negedge clk);
        checks++;
        if (s_stb_o !== 3'b0 || s_cyc_o !== 3'b0 || busy_o !== 1'b0) begin
            fails++; $display("[TB] FAIL cyc_drop_idle: got stb=%b cyc=%b busy=%b required 0", s_stb_o, s_cyc_o, busy_o);
        end
        checks++;
        begin
            logic seen = 1'b0;
            repeat (4) begin
                if (m_ack_o || m_err_o) seen = 1'b1;
                @(negedge clk);
            end
            if (seen) begin
                fails++; $display("[TB] FAIL cyc_drop_noresp: got a response pulse required none");
            end
        end
        run_access(32'hF800_0010, 32'h0, 4'hF, 1'b0, 1, 0, 32'h0BAD_CAFE, 40, o);
        checks++;
        if (o.n !== 4 || o.ack !== 1'b1 || o.dat !== 32'h0BAD_CAFE) begin
            fails++; $display("[TB] FAIL cyc_drop_next: got n=%0d ack=%b dat=%h required 4 1 0badcafe", o.n, o.ack, o.dat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        obs_t o;
        logic seen = 1'b0;
        run_access(32'h8000_0300, 32'h0, 4'hF, 1'b0, -1, 0, 32'h0, 2, o);
        m_cyc = 1'b1; m_stb = 1'b1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({s_cyc_o, s_stb_o, m_ack_o, m_err_o, busy_o} !== 9'b0 || m_dat_o !== 32'h0 || !o.busy_end) begin
            fails++; $display("[TB] FAIL reset_mid: got ctl=%b dat=%h busy_before=%b", {s_cyc_o, s_stb_o, m_ack_o, m_err_o, busy_o}, m_dat_o, o.busy_end);
        end
        m_cyc = 1'b0; m_stb = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (m_ack_o || m_err_o) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            fails++; $display("[TB] FAIL reset_mid_noresp: got a response pulse required none");
        end
        run_access(32'h8000_0400, 32'h0, 4'hF, 1'b0, 0, 0, 32'h5555_AAAA, 40, o);
        checks++;
        if (o.n !== 3 || o.ack !== 1'b1 || o.dat !== 32'h5555_AAAA) begin
            fails++; $display("[TB] FAIL reset_mid_next: got n=%0d ack=%b dat=%h required 3 1 5555aaaa", o.n, o.ack, o.dat);
        end
        @(negedge clk);
    endtask

    task automatic test_silent_slave;
        obs_t o;
        run_access(32'hF000_0040, 32'h0, 4'hF, 1'b0, -1, 0, 32'h0, 300, o);
`ifdef TWPM_WB_TIMEOUT_EN
        checks++;
        if (o.n !== TMO + 2 || o.err !== 1'b1 || o.ack !== 1'b0 || o.dat !== BAD || o.stb_cycles != TMO) begin
            fails++; $display("[TB] FAIL timeout: got n=%0d err=%b dat=%h stb_cycles=%0d required n=%0d", o.n, o.err, o.dat, o.stb_cycles, TMO + 2);
        end
`else
        checks++;
        if (o.n !== -1 || o.busy_end !== 1'b1 || o.stb_cycles != 300) begin
            fails++; $display("[TB] FAIL silent_wait: got n=%0d busy=%b stb_cycles=%0d required -1 1 300", o.n, o.busy_end, o.stb_cycles);
        end
`endif
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || s_stb_o !== 3'b0) begin
            fails++; $display("[TB] FAIL silent_end: got busy=%b stb=%b required 0", busy_o, s_stb_o);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_cyc_drop;
        test_reset_mid;
        test_silent_slave;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
